// File: rtl/uart_pkg.sv
// uart_pkg
// Shared constants for the UART baud-rate generator: default divisor widths
// and the tx prescaler terminal counts for 16x and 8x oversampling.
package uart_pkg;

  // Default width of the integer part of the oversample divisor.
  localparam int BRD_INT_W  = 12;
  // Default width of the fractional part, in sixteenths of a pclk cycle.
  localparam int BRD_FRAC_W = 4;

  // A bit lasts 16 oversample ticks, so the bit strobe fires when the
  // prescaler shows 15.
  localparam logic [3:0] OVS16_LAST = 4'd15;
  // In 8x mode a bit lasts 8 ticks, so only the low three prescaler bits
  // are compared.
  localparam logic [2:0] OVS8_LAST  = 3'd7;

endpackage

// File: rtl/uart_frac_div.sv
// uart_frac_div
// Fractional divider that produces the oversampling strobe. The period is
// sh_int cycles, stretched by one cycle whenever the fraction accumulator
// overflows. The average period is therefore sh_int + sh_frac/16 cycles.
//
// Ports:
//   pclk        system clock, rising edge
//   prst        asynchronous active-high reset
//   en_i        UART enable; low holds the divider cleared (shadow retained)
//   brdInt_i    integer divisor input
//   brdFrac_i   fractional divisor input (sixteenths)
//   brdWr_i     one-cycle divisor write pulse
//   rxShift_o   one-cycle oversample strobe
//   cfgErr_o    enabled with an active integer divisor of zero
module uart_frac_div
  import uart_pkg::*;
#(
  parameter int INT_W  = BRD_INT_W,
  parameter int FRAC_W = BRD_FRAC_W
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              en_i,
  input  logic [INT_W-1:0]  brdInt_i,
  input  logic [FRAC_W-1:0] brdFrac_i,
  input  logic              brdWr_i,
  output logic              rxShift_o,
  output logic              cfgErr_o
);

  logic [INT_W-1:0]  shIntQ, shIntD;
  logic [FRAC_W-1:0] shFracQ, shFracD;
  logic [INT_W-1:0]  stIntQ, stIntD;
  logic [FRAC_W-1:0] stFracQ, stFracD;
  logic              pendQ, pendD;
  logic [INT_W-1:0]  cntQ, cntD;
  logic [FRAC_W-1:0] accQ, accD;
  logic              carryQ, carryD;

  logic              intZero;
  logic [INT_W:0]    lenM1;
  logic              rxShift;
  logic [FRAC_W:0]   accSum;
  logic [INT_W-1:0]  nxtInt;
  logic [FRAC_W-1:0] nxtFrac;
  logic              wrPend;
  logic              applyDiv;

  // Strobe decode and divider update. A write arriving in the same cycle as
  // a strobe is forwarded straight into the shadow, so it governs the very
  // next period. With a zero divisor no strobe can ever come, so a pending
  // divisor is applied at once instead of waiting for one.
  always_comb begin
    shIntD  = shIntQ;
    shFracD = shFracQ;
    stIntD  = stIntQ;
    stFracD = stFracQ;
    pendD   = pendQ;
    cntD    = cntQ;
    accD    = accQ;
    carryD  = carryQ;

    intZero  = (shIntQ == '0);
    lenM1    = {1'b0, shIntQ} + {{INT_W{1'b0}}, carryQ} - {{INT_W{1'b0}}, 1'b1};
    rxShift  = en_i & ~intZero & ({1'b0, cntQ} == lenM1);
    accSum   = {1'b0, accQ} + {1'b0, shFracQ};
    nxtInt   = brdWr_i ? brdInt_i  : stIntQ;
    nxtFrac  = brdWr_i ? brdFrac_i : stFracQ;
    wrPend   = brdWr_i | pendQ;
    applyDiv = en_i & wrPend & (rxShift | intZero);

    if (!en_i) begin
      cntD   = '0;
      accD   = '0;
      carryD = 1'b0;
      pendD  = 1'b0;
      if (brdWr_i) begin
        shIntD  = brdInt_i;
        shFracD = brdFrac_i;
      end
    end else begin
      stIntD  = nxtInt;
      stFracD = nxtFrac;
      pendD   = wrPend;
      if (rxShift) begin
        cntD             = '0;
        {carryD, accD}   = accSum;
      end else if (intZero) begin
        cntD = '0;
      end else begin
        cntD = cntQ + 1'b1;
      end
      if (applyDiv) begin
        shIntD  = nxtInt;
        shFracD = nxtFrac;
        accD    = '0;
        carryD  = 1'b0;
        pendD   = 1'b0;
      end
    end
  end

  // Divider state register.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      shIntQ  <= '0;
      shFracQ <= '0;
      stIntQ  <= '0;
      stFracQ <= '0;
      pendQ   <= 1'b0;
      cntQ    <= '0;
      accQ    <= '0;
      carryQ  <= 1'b0;
    end else begin
      shIntQ  <= shIntD;
      shFracQ <= shFracD;
      stIntQ  <= stIntD;
      stFracQ <= stFracD;
      pendQ   <= pendD;
      cntQ    <= cntD;
      accQ    <= accD;
      carryQ  <= carryD;
    end
  end

  assign rxShift_o = rxShift;
  assign cfgErr_o  = en_i & intZero;

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Baud-rate generator top: fractional divider for the oversample strobe plus
// a 4-bit tx prescaler that turns every 16th (or 8th) oversample strobe into
// a bit strobe.
//
// Ports:
//   pclk          system clock, rising edge
//   prst          asynchronous active-high reset
//   apb_en        UART enable; low holds the block cleared
//   apb_bsel      0: 16x oversampling, 1: 8x oversampling
//   apb_brd_int   integer part of the oversample period (pclk cycles)
//   apb_brd_frac  fractional part of the period (sixteenths)
//   apb_brd_wr    one-cycle divisor write pulse
//   brg_rx_shift  one-cycle oversample strobe
//   brg_tx_shift  one-cycle bit strobe, coincident with an rx strobe
//   brg_cfg_err   enabled with an active integer divisor of zero
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BRD_INT_W  = uart_pkg::BRD_INT_W,
  parameter int BRD_FRAC_W = uart_pkg::BRD_FRAC_W
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  apb_en,
  input  logic                  apb_bsel,
  input  logic [BRD_INT_W-1:0]  apb_brd_int,
  input  logic [BRD_FRAC_W-1:0] apb_brd_frac,
  input  logic                  apb_brd_wr,
  output logic                  brg_rx_shift,
  output logic                  brg_tx_shift,
  output logic                  brg_cfg_err
);

  logic       rxShift;
  logic [3:0] txCntQ, txCntD;
  logic       txHit;

  uart_frac_div #(
    .INT_W  (BRD_INT_W),
    .FRAC_W (BRD_FRAC_W)
  ) uFracDiv (
    .pclk      (pclk),
    .prst      (prst),
    .en_i      (apb_en),
    .brdInt_i  (apb_brd_int),
    .brdFrac_i (apb_brd_frac),
    .brdWr_i   (apb_brd_wr),
    .rxShift_o (rxShift),
    .cfgErr_o  (brg_cfg_err)
  );

  // The prescaler is never reset on a bsel change, so switching modes
  // simply moves the terminal count the next bit strobe waits for.
  always_comb begin
    txCntD = txCntQ;
    if (!apb_en) begin
      txCntD = '0;
    end else if (rxShift) begin
      txCntD = txCntQ + 4'd1;
    end
    txHit = apb_bsel ? (txCntQ[2:0] == OVS8_LAST) : (txCntQ == OVS16_LAST);
  end

  // Tx prescaler register.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      txCntQ <= '0;
    end else begin
      txCntQ <= txCntD;
    end
  end

  assign brg_rx_shift = rxShift;
  assign brg_tx_shift = rxShift & txHit;

endmodule
